// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: fetches bitmap rows and streams a full-window RGB565 frame to an ST7735-class SPI LCD.
module lcd_frame_streamer #(
   parameter int          LCD_H    = 162,
   parameter int          LCD_W    = 132,
   parameter int          CLK_DIV  = 2,
   parameter logic [15:0] FG_COLOR = 16'hFFFF,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [7:0]       ram_addr,
   input  logic [LCD_W-1:0] ram_data,
   output logic             lcd_sclk,
   output logic             lcd_mosi,
   output logic             lcd_cs_n,
   output logic             lcd_dc,
   output logic             busy,
   output logic             frame_done
);
   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int CW = $clog2(LCD_W + 1);
   typedef enum logic [2:0] {IDLE, HDR, FETCH, PIX, FIN} state_t;
   state_t state;
   logic [PW-1:0] ph;
   logic [3:0] nb, hi, hn;
   logic [15:0] sh, pw, fw_word;
   logic [7:0] hb;
   logic [CW-1:0] cl;
   logic [LCD_W-1:0] rowbuf;
   logic fw, ph_end, bit_end, unit_end;
   function automatic logic [7:0] hdr_byte(input logic [3:0] i);
      return i == 4'd0 ? 8'h2A : i == 4'd4 ? 8'(LCD_W - 1) : i == 4'd5 ? 8'h2B :
             i == 4'd9 ? 8'(LCD_H - 1) : i == 4'd10 ? 8'h2C : 8'h00;
   endfunction
   function automatic logic [15:0] color(input logic b);
      return b ? FG_COLOR : BG_COLOR;
   endfunction
   assign lcd_mosi = sh[15];
   always_comb begin
      hn = hi + 4'd1;
      hb = hdr_byte(hn);
      pw = color(rowbuf[0]);
      fw_word = color(ram_data[0]);
      ph_end = ph == PW'(CLK_DIV - 1);
      bit_end = ph_end && lcd_sclk;
      unit_end = bit_end && nb == 4'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         lcd_cs_n <= 1'b1;
         lcd_sclk <= 1'b0;
         lcd_dc <= 1'b0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         ram_addr <= 8'd0;
         ph <= '0;
         nb <= 4'd0;
         hi <= 4'd0;
         sh <= 16'd0;
         cl <= '0;
         rowbuf <= '0;
         fw <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (start && !frame_done) begin
                  state <= HDR;
                  lcd_cs_n <= 1'b0;
                  busy <= 1'b1;
                  ram_addr <= 8'd0;
                  hi <= 4'd0;
                  sh <= {8'h2A, 8'h00};
                  lcd_dc <= 1'b0;
                  nb <= 4'd7;
                  ph <= '0;
               end
            end
            HDR, PIX: begin
               ph <= ph_end ? '0 : ph + PW'(1);
               if (ph_end) lcd_sclk <= !lcd_sclk;
               if (bit_end && nb != 4'd0) begin
                  sh <= sh << 1;
                  nb <= nb - 4'd1;
               end
               if (unit_end) begin
                  if (state == HDR) begin
                     if (hi == 4'd10) state <= FETCH;
                     else begin
                        hi <= hn;
                        sh <= {hb, 8'h00};
                        lcd_dc <= !(hn == 4'd5 || hn == 4'd10);
                        nb <= 4'd7;
                     end
                  end else if (cl == '0) begin
                     if (ram_addr == 8'(LCD_H - 1)) state <= FIN;
                     else begin
                        ram_addr <= ram_addr + 8'd1;
                        state <= FETCH;
                     end
                  end else begin
                     cl <= cl - CW'(1);
                     sh <= pw;
                     rowbuf <= rowbuf >> 1;
                     nb <= 4'd15;
                  end
               end
            end
            FETCH: begin
               // address settles in the first cycle, row is captured at the end of the second
               fw <= 1'b1;
               if (fw) begin
                  fw <= 1'b0;
                  rowbuf <= ram_data >> 1;
                  sh <= fw_word;
                  nb <= 4'd15;
                  cl <= CW'(LCD_W - 1);
                  lcd_dc <= 1'b1;
                  state <= PIX;
               end
            end
            FIN: begin
               lcd_cs_n <= 1'b1;
               frame_done <= 1'b1;
               busy <= 1'b0;
               sh <= 16'd0;
               lcd_dc <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// tb_lcd_frame_streamer: two small configurations decoded by an SPI byte model and checked against hand-computed streams.
module tb_lcd_frame_streamer;
   localparam int NB [2] = '{27, 29};
   localparam int HK [2] = '{2, 3};
   localparam int DV [2] = '{1, 3};
   localparam int CY [2] = '{438, 1400};
   localparam logic [7:0] EXP [2][29] = '{
      '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C,
        8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00},
      '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2C,
        8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h1F,
        8'h00, 8'h1F, 8'hF8, 8'h00, 8'hF8, 8'h00,
        8'hF8, 8'h00, 8'hF8, 8'h00, 8'h00, 8'h1F}};
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, dclr = 1'b1;
   logic [7:0] ra [2];
   logic [3:0] rd0;
   logic [2:0] rd1;
   logic sclk [2], mosi [2], cs_n [2], dc [2], busy [2], done [2];
   int checks = 0, failures = 0, cyc = 0;
   logic ps [2], pm [2], dcf [2];
   logic [7:0] acc [2], pa [2], mx [2];
   int nbit [2], nby [2], spur [2], unst [2], perr [2], hr [2], dcerr [2], fd [2], ups [2], ts [2], td [2];
   logic [7:0] by [2][64];
   logic bd [2][64];
   always #5 clk = !clk;
   assign rd0 = ra[0] == 8'd0 ? 4'b0101 : 4'b1000;
   assign rd1 = ra[1] == 8'd0 ? 3'b001 : ra[1] == 8'd1 ? 3'b110 : 3'b011;
   lcd_frame_streamer #(.LCD_H(2), .LCD_W(4), .CLK_DIV(1)) u0 (
      .clk(clk), .rst(rst), .start(start), .ram_addr(ra[0]), .ram_data(rd0),
      .lcd_sclk(sclk[0]), .lcd_mosi(mosi[0]), .lcd_cs_n(cs_n[0]), .lcd_dc(dc[0]),
      .busy(busy[0]), .frame_done(done[0]));
   lcd_frame_streamer #(.LCD_H(3), .LCD_W(3), .CLK_DIV(3), .FG_COLOR(16'hF800), .BG_COLOR(16'h001F)) u1 (
      .clk(clk), .rst(rst), .start(start), .ram_addr(ra[1]), .ram_data(rd1),
      .lcd_sclk(sclk[1]), .lcd_mosi(mosi[1]), .lcd_cs_n(cs_n[1]), .lcd_dc(dc[1]),
      .busy(busy[1]), .frame_done(done[1]));
   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         ps[k] <= sclk[k];
         pm[k] <= mosi[k];
         pa[k] <= ra[k];
         if (start && !busy[k] && !done[k]) ts[k] <= cyc;
         if (dclr) begin
            nbit[k] <= 0; nby[k] <= 0; spur[k] <= 0; unst[k] <= 0; perr[k] <= 0;
            hr[k] <= 0; dcerr[k] <= 0; fd[k] <= 0; ups[k] <= 0; mx[k] <= 8'd0;
         end else begin
            if (sclk[k] && !ps[k]) begin
               if (cs_n[k]) spur[k] <= spur[k] + 1;
               acc[k] <= {acc[k][6:0], mosi[k]};
               if (nbit[k] == 0) dcf[k] <= dc[k];
               else if (dc[k] !== dcf[k]) dcerr[k] <= dcerr[k] + 1;
               if (nbit[k] == 7) begin
                  if (nby[k] < 64) begin
                     by[k][nby[k]] <= {acc[k][6:0], mosi[k]};
                     bd[k][nby[k]] <= dcf[k];
                  end
                  nby[k] <= nby[k] + 1;
                  nbit[k] <= 0;
               end else nbit[k] <= nbit[k] + 1;
            end
            if (sclk[k] && mosi[k] !== pm[k]) unst[k] <= unst[k] + 1;
            if (sclk[k]) hr[k] <= hr[k] + 1;
            else if (ps[k]) begin
               if (hr[k] != DV[k]) perr[k] <= perr[k] + 1;
               hr[k] <= 0;
            end
            if (done[k]) begin
               fd[k] <= fd[k] + 1;
               td[k] <= cyc;
            end
            if (ra[k] == pa[k] + 8'd1) ups[k] <= ups[k] + 1;
            if (ra[k] > mx[k]) mx[k] <= ra[k];
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask
   task automatic clear();
      @(posedge clk); #1 dclr = 1'b1;
      @(posedge clk); #1 dclr = 1'b0;
   endtask
   task automatic wait_done(input int k);
      int i;
      for (i = 0; i < 5000 && done[k] !== 1'b1; i++) @(negedge clk);
      chk($sformatf("done_timeout%0d", k), 32'(i < 5000), 32'd1);
   endtask
   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("nbytes%0d", k), nby[k], NB[k]);
         for (int i = 0; i < NB[k]; i++) begin
            chk($sformatf("byte%0d_%0d", k, i), 32'(by[k][i]), 32'(EXP[k][i]));
            chk($sformatf("dc%0d_%0d", k, i), 32'(bd[k][i]), 32'(!(i == 0 || i == 5 || i == 10)));
         end
         chk($sformatf("frame_done_count%0d", k), fd[k], 1);
         chk($sformatf("cycles%0d", k), td[k] - ts[k], CY[k]);
         chk($sformatf("spurious_sclk%0d", k), spur[k], 0);
         chk($sformatf("mosi_unstable%0d", k), unst[k], 0);
         chk($sformatf("sclk_high_len%0d", k), perr[k], 0);
         chk($sformatf("dc_in_byte%0d", k), dcerr[k], 0);
         chk($sformatf("row_steps%0d", k), ups[k], HK[k] - 1);
         chk($sformatf("addr_max%0d", k), 32'(mx[k]), HK[k] - 1);
         chk($sformatf("cs_after%0d", k), 32'(cs_n[k]), 1);
         chk($sformatf("busy_after%0d", k), 32'(busy[k]), 0);
      end
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; dclr = 1'b0;
      repeat (100) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("idle_cs%0d", k), 32'(cs_n[k]), 1);
         chk($sformatf("idle_sclk%0d", k), 32'(sclk[k]), 0);
         chk($sformatf("idle_busy%0d", k), 32'(busy[k]), 0);
         chk($sformatf("idle_addr%0d", k), 32'(ra[k]), 0);
         chk($sformatf("idle_done%0d", k), fd[k], 0);
      end
      pulse_start();
      repeat (50) @(posedge clk);
      pulse_start();
      wait_done(0);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("start_on_done_ignored", 32'(busy[0]), 0);
      wait_done(1);
      repeat (3) @(negedge clk);
      check_all();
      clear();
      pulse_start();
      repeat (200) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("abort_cs%0d", k), 32'(cs_n[k]), 1);
         chk($sformatf("abort_sclk%0d", k), 32'(sclk[k]), 0);
         chk($sformatf("abort_mosi%0d", k), 32'(mosi[k]), 0);
         chk($sformatf("abort_dc%0d", k), 32'(dc[k]), 0);
         chk($sformatf("abort_busy%0d", k), 32'(busy[k]), 0);
         chk($sformatf("abort_done%0d", k), 32'(done[k]), 0);
         chk($sformatf("abort_addr%0d", k), 32'(ra[k]), 0);
      end
      clear();
      pulse_start();
      wait_done(0);
      wait_done(1);
      repeat (3) @(negedge clk);
      check_all();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
